kbd_matrix_scan: RTL and testbench
==================================

KBD_MATRIX_SCAN -- requirements
Module: kbd_matrix_scan

Interface
REQ-001 SHALL have parameter KEY_ROWS, default 9, number of PS/2-driven matrix rows.
REQ-002 SHALL have parameter JOY_N, default 2, number of joystick channels; each channel occupies 3 rows after the key rows.
REQ-003 SHALL have parameter ALL_ADDR, default 8'h30, address returning the OR of all rows.
REQ-004 SHALL have parameter TAP_HOLD, default 16'd4096, the maximum number of cycles a released-but-unread key stays latched.
REQ-005 SHALL have port clk_sys, input, 1, the only clock.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port ps2_key, input, 11: [7:0] scancode, [8] extended, [9] pressed, [10] toggles on every event.
REQ-008 SHALL have port addr, input, 8, the row select.
REQ-009 SHALL have port rd, input, 1, a one-cycle CPU read strobe for the current addr.
REQ-010 SHALL have port joy, input, 32*JOY_N; channel c is joy[32c+5:32c], with bits right,left,down,up,fire1,fire2 at [0..5].
REQ-011 SHALL have port kb_rows, output, 8, the selected row data with active-high bits.
REQ-012 SHALL have port fn, output, 11, the F1..F11 held state, with bit i-1 = Fi.
REQ-013 SHALL have port modif, output, 3, {ctrl, alt, right shift} held state.

Function
REQ-014 SHALL detect an event when registered ps2_key[10] differs from the current value, capture code, ext and pressed, and apply the event on the following cycle, giving 2 cycles from toggle to matrix update.
REQ-015 SHALL map {ext, code} through the package lookup to (row, bit, valid); invalid codes SHALL change no matrix bit.
REQ-016 SHALL drive fn and modif from the same captured events regardless of matrix validity; 8'h14 and 8'h59 SHALL update both modif and the matrix.
REQ-017 SHALL keep a per-key state for each key bit: IDLE, DOWN, or LATCHED; the matrix bit SHALL be 1 in DOWN or LATCHED.
REQ-018 SHALL make the key state transitions as follows:
- a press moves any state to DOWN and clears the key's seen flag;
- a release from DOWN goes to IDLE if seen=1, else to LATCHED;
- a release in IDLE or LATCHED is ignored.
REQ-019 SHALL set seen for every bit of a row on a rd cycle whose addr selects that row, or on any rd cycle with addr==ALL_ADDR.
REQ-020 SHALL move a LATCHED key to IDLE on the cycle after its seen flag is set, or after TAP_HOLD cycles in LATCHED, whichever comes first; a single shared counter restarting on each new LATCHED entry is permitted.
REQ-021 SHALL, when a press and a seen-set hit the same key in the same cycle, let the press win: state DOWN, seen=0.
REQ-022 SHALL register joystick rows each cycle from joy; they SHALL not be latched.
REQ-023 SHALL, for channel c, place row base R=KEY_ROWS+3c with these directional assignments:
- up-left: R bits 1,5;
- down-left: R+1 bits 0,4;
- up-right: R+1 bits 1,5;
- down-right: R+2 bits 1,5;
- up: R bits 0,4;
- down: R+2 bits 0,4;
- left: R bits 2,6;
- right: R+2 bits 2,6.
REQ-024 SHALL give directions first-match priority in the order UL, DL, UR, DR, U, D, L, R, so exactly one direction is active.
REQ-025 SHALL map fire1 to R bits 3,7 and fire2 to R+2 bits 3,7, independent of direction.
REQ-026 SHALL drive kb_rows combinationally as follows:
- addr==ALL_ADDR gives the OR of all KEY_ROWS+3*JOY_N rows;
- 1<=addr<=KEY_ROWS+3*JOY_N gives row addr-1;
- any other addr gives 0.

Reset
REQ-027 SHALL, with reset high at a clock edge, set all key states to IDLE, seen to 1, fn=0, modif=0, joystick rows=0, clear the pending event and the TAP_HOLD counter, and load the toggle register from ps2_key[10] so no event follows reset.
REQ-028 SHALL, while reset is high, ignore events and joystick inputs; kb_rows SHALL read 0 for every addr on the cycle after reset asserts.

Structure
REQ-029 SHALL have package kbd_pkg holding the key state enum, the scancode-to-(row,bit,valid) lookup function, the F-key and modifier scancode constants, and the joystick bit index constants.
REQ-030 SHALL implement per-channel joystick decode as sub-module kbd_joy_rows (6 inputs, 3x8 outputs), instantiated JOY_N times.
REQ-031 SHALL require KEY_ROWS+3*JOY_N <= 255 and ALL_ADDR outside 1..KEY_ROWS+3*JOY_N, each checked by an elaboration assertion.

Verification
REQ-032 SHALL cover this scenario: press code 8'h1c (A), then with addr=3 -> kb_rows=8'h02 two cycles after the toggle; release, rd at addr=3 -> 8'h00 after the next cycle.
REQ-033 SHALL cover this scenario: press and release 8'h32 (B) with no rd -> addr=3 reads 8'h04 until rd at addr=3, then 8'h00; with no rd at all -> clears after exactly TAP_HOLD cycles.
REQ-034 SHALL cover this scenario: JOY_N=2, joy channel 1 up+left+fire1 -> addr=13 reads 8'hAA and addrs 14 and 15 read 8'h00; addr=ALL_ADDR includes 8'hAA.
REQ-035 SHALL cover this scenario: press a key, then on the same cycle apply a rd of its row and a repeat press event -> the key stays DOWN and a later release latches.
REQ-036 SHALL cover this scenario: hold 8'h14 and 8'h05, assert reset for 1 cycle with ps2_key[10] toggling -> fn=0, modif=0, all rows 0, and no event applied after release of reset.
REQ-037 SHALL cover this scenario: addr=0 and addr=KEY_ROWS+3*JOY_N+1 with keys held -> kb_rows=8'h00.

Source files
------------

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types, scancode matrix map and key constants for the matrix scanner
package kbd_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE    = 2'd0,
    KEY_DOWN    = 2'd1,
    KEY_LATCHED = 2'd2
  } key_st_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] row;
    logic [2:0] bit_idx;
  } kbd_loc_t;

  // fn bit i-1 follows Fi; modif is {ctrl, alt, right shift}
  localparam logic [7:0] FKEY_CODE [11] = '{8'h05, 8'h06, 8'h04, 8'h0c, 8'h03, 8'h0b,
                                            8'h83, 8'h0a, 8'h01, 8'h09, 8'h78};
  localparam logic [7:0] MOD_CODE [3] = '{8'h59, 8'h11, 8'h14};

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE1 = 4;
  localparam int JOY_FIRE2 = 5;

  // Table entries are octal {row, bit}: 7'o21 is row 2 bit 1
  function automatic kbd_loc_t kbd_lookup(input logic ext, input logic [7:0] code);
    logic [6:0] rb;
    kbd_loc_t   loc;
    rb        = '0;
    loc.valid = 1'b1;
    case ({ext, code})
      9'h045: rb = 7'o00;  9'h016: rb = 7'o01;  9'h01e: rb = 7'o02;  9'h026: rb = 7'o03;
      9'h025: rb = 7'o04;  9'h02e: rb = 7'o05;  9'h036: rb = 7'o06;  9'h03d: rb = 7'o07;
      9'h03e: rb = 7'o10;  9'h046: rb = 7'o11;  9'h04e: rb = 7'o12;  9'h055: rb = 7'o13;
      9'h05d: rb = 7'o14;  9'h054: rb = 7'o15;  9'h05b: rb = 7'o16;  9'h04c: rb = 7'o17;
      9'h052: rb = 7'o20;  9'h01c: rb = 7'o21;  9'h032: rb = 7'o22;  9'h021: rb = 7'o23;
      9'h023: rb = 7'o24;  9'h024: rb = 7'o25;  9'h02b: rb = 7'o26;  9'h034: rb = 7'o27;
      9'h033: rb = 7'o30;  9'h043: rb = 7'o31;  9'h03b: rb = 7'o32;  9'h042: rb = 7'o33;
      9'h04b: rb = 7'o34;  9'h03a: rb = 7'o35;  9'h031: rb = 7'o36;  9'h044: rb = 7'o37;
      9'h04d: rb = 7'o40;  9'h015: rb = 7'o41;  9'h02d: rb = 7'o42;  9'h01b: rb = 7'o43;
      9'h02c: rb = 7'o44;  9'h03c: rb = 7'o45;  9'h02a: rb = 7'o46;  9'h01d: rb = 7'o47;
      9'h022: rb = 7'o50;  9'h035: rb = 7'o51;  9'h01a: rb = 7'o52;  9'h041: rb = 7'o53;
      9'h049: rb = 7'o54;  9'h04a: rb = 7'o55;  9'h00e: rb = 7'o56;  9'h061: rb = 7'o57;
      9'h059: rb = 7'o60;  9'h014: rb = 7'o61;  9'h011: rb = 7'o62;  9'h058: rb = 7'o63;
      9'h005: rb = 7'o65;  9'h006: rb = 7'o66;  9'h004: rb = 7'o67;
      9'h00c: rb = 7'o70;  9'h003: rb = 7'o71;  9'h076: rb = 7'o72;  9'h00d: rb = 7'o73;
      9'h066: rb = 7'o75;  9'h05a: rb = 7'o77;
      9'h029: rb = 7'o100; 9'h16c: rb = 7'o101; 9'h171: rb = 7'o103; 9'h16b: rb = 7'o104;
      9'h175: rb = 7'o105; 9'h172: rb = 7'o106; 9'h174: rb = 7'o107;
      default: loc.valid = 1'b0;
    endcase
    loc.row     = {4'd0, rb[6:3]};
    loc.bit_idx = rb[2:0];
    return loc;
  endfunction

endpackage

// File: rtl/kbd_matrix_scan_if.sv
// rtl/kbd_matrix_scan_if.sv - CPU row-read bus of the keyboard matrix scanner
interface kbd_matrix_scan_if;
  logic [7:0] addr;
  logic       rd;
  logic [7:0] kb_rows;

  modport master (output addr, output rd, input kb_rows);
  modport slave  (input addr, input rd, output kb_rows);
endinterface

// File: rtl/kbd_joy_rows.sv
// rtl/kbd_joy_rows.sv - one joystick channel decoded onto three matrix rows
module kbd_joy_rows (
  input  logic       up_i,
  input  logic       down_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       fire1_i,
  input  logic       fire2_i,
  output logic [7:0] row0_o,
  output logic [7:0] row1_o,
  output logic [7:0] row2_o
);

  // Diagonals are tested first so exactly one direction ever lights
  always_comb begin
    row0_o = {fire1_i, 3'b000, fire1_i, 3'b000};
    row1_o = 8'h00;
    row2_o = {fire2_i, 3'b000, fire2_i, 3'b000};
    if (up_i && left_i)         row0_o = row0_o | 8'h22;
    else if (down_i && left_i)  row1_o = row1_o | 8'h11;
    else if (up_i && right_i)   row1_o = row1_o | 8'h22;
    else if (down_i && right_i) row2_o = row2_o | 8'h22;
    else if (up_i)              row0_o = row0_o | 8'h11;
    else if (down_i)            row2_o = row2_o | 8'h11;
    else if (left_i)            row0_o = row0_o | 8'h44;
    else if (right_i)           row2_o = row2_o | 8'h44;
  end

endmodule

// File: rtl/kbd_matrix_scan.sv
// rtl/kbd_matrix_scan.sv - PS/2 events and joysticks folded into a CPU-readable key matrix
module kbd_matrix_scan
  import kbd_pkg::*;
#(
  parameter int          KEY_ROWS = 9,
  parameter int          JOY_N    = 2,
  parameter logic [7:0]  ALL_ADDR = 8'h30,
  parameter logic [15:0] TAP_HOLD = 16'd4096
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [10:0]          ps2_key,
  input  logic [32*JOY_N-1:0]  joy,
  output logic [10:0]          fn,
  output logic [2:0]           modif,
  kbd_matrix_scan_if.slave     bus
);

  localparam int NROWS = KEY_ROWS + 3*JOY_N;
  localparam int NKEYS = KEY_ROWS*8;

  if (NROWS > 255) begin : g_bad_rows
    $error("kbd_matrix_scan: KEY_ROWS+3*JOY_N exceeds 255");
  end
  if ((int'(ALL_ADDR) >= 1) && (int'(ALL_ADDR) <= NROWS)) begin : g_bad_all
    $error("kbd_matrix_scan: ALL_ADDR collides with a row address");
  end

  logic        tog_q, ev_pend_q, ev_ext_q, ev_press_q;
  logic [7:0]  ev_code_q;
  logic [10:0] fn_q, fn_d;
  logic [2:0]  modif_q, modif_d;
  key_st_e     key_st_q [NKEYS];
  key_st_e     key_st_d [NKEYS];
  logic [NKEYS-1:0] seen_q, seen_d, seen_set;
  logic [KEY_ROWS-1:0] seen_row;
  logic [15:0] hold_cnt_q;
  logic        hold_run_q, hold_expire, latch_start;
  logic [7:0]  joy_rows_d [3*JOY_N];
  logic [7:0]  joy_rows_q [3*JOY_N];
  logic [JOY_N-1:0] joy_unused;
  logic [NROWS-1:0][7:0] row_data;
  logic [7:0]  all_or, sel_row;
  kbd_loc_t    loc;
  logic        ev_hit;
  int          ev_key;

  assign fn    = fn_q;
  assign modif = modif_q;

  assign loc    = kbd_lookup(ev_ext_q, ev_code_q);
  assign ev_hit = ev_pend_q && loc.valid && (int'(loc.row) < KEY_ROWS);
  assign ev_key = int'(loc.row)*8 + int'(loc.bit_idx);
  assign hold_expire = hold_run_q && (hold_cnt_q == TAP_HOLD - 16'd1);

  for (genvar r = 0; r < KEY_ROWS; r++) begin : g_krow
    assign seen_row[r] = bus.rd && ((bus.addr == ALL_ADDR) || (int'(bus.addr) == r + 1));
    assign seen_set[r*8 +: 8] = {8{seen_row[r]}};
    for (genvar b = 0; b < 8; b++) begin : g_kbit
      assign row_data[r][b] = (key_st_q[r*8+b] != KEY_IDLE);
    end
  end

  for (genvar c = 0; c < JOY_N; c++) begin : g_joy
    kbd_joy_rows u_joy_rows (
      .up_i    (joy[32*c+JOY_UP]),
      .down_i  (joy[32*c+JOY_DOWN]),
      .left_i  (joy[32*c+JOY_LEFT]),
      .right_i (joy[32*c+JOY_RIGHT]),
      .fire1_i (joy[32*c+JOY_FIRE1]),
      .fire2_i (joy[32*c+JOY_FIRE2]),
      .row0_o  (joy_rows_d[3*c]),
      .row1_o  (joy_rows_d[3*c+1]),
      .row2_o  (joy_rows_d[3*c+2])
    );
    assign joy_unused[c] = ^joy[32*c+6 +: 26];
    for (genvar j = 0; j < 3; j++) begin : g_jrow
      assign row_data[KEY_ROWS+3*c+j] = joy_rows_q[3*c+j];
    end
  end

  // A press beats a same-cycle read; an unread release parks the key in LATCHED
  always_comb begin
    latch_start = 1'b0;
    for (int k = 0; k < NKEYS; k++) begin
      key_st_d[k] = key_st_q[k];
      seen_d[k]   = seen_q[k] | seen_set[k];
      if (ev_hit && (ev_key == k) && ev_press_q) begin
        key_st_d[k] = KEY_DOWN;
        seen_d[k]   = 1'b0;
      end else if (ev_hit && (ev_key == k) && (key_st_q[k] == KEY_DOWN)) begin
        if (seen_q[k]) begin
          key_st_d[k] = KEY_IDLE;
        end else begin
          key_st_d[k] = KEY_LATCHED;
          latch_start = 1'b1;
        end
      end else if ((key_st_q[k] == KEY_LATCHED) && (seen_q[k] || hold_expire)) begin
        key_st_d[k] = KEY_IDLE;
      end
    end
  end

  always_comb begin
    fn_d    = fn_q;
    modif_d = modif_q;
    for (int i = 0; i < 11; i++) begin
      if (ev_pend_q && !ev_ext_q && (ev_code_q == FKEY_CODE[i])) fn_d[i] = ev_press_q;
    end
    for (int i = 0; i < 3; i++) begin
      if (ev_pend_q && (ev_code_q == MOD_CODE[i])) modif_d[i] = ev_press_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
    if (ps2_key[10] != tog_q) begin
      ev_code_q  <= ps2_key[7:0];
      ev_ext_q   <= ps2_key[8];
      ev_press_q <= ps2_key[9];
    end
    if (reset) begin
      ev_pend_q  <= 1'b0;
      fn_q       <= '0;
      modif_q    <= '0;
      seen_q     <= '1;
      hold_cnt_q <= '0;
      hold_run_q <= 1'b0;
      for (int k = 0; k < NKEYS; k++) key_st_q[k] <= KEY_IDLE;
      for (int j = 0; j < 3*JOY_N; j++) joy_rows_q[j] <= '0;
    end else begin
      ev_pend_q <= (ps2_key[10] != tog_q);
      fn_q      <= fn_d;
      modif_q   <= modif_d;
      seen_q    <= seen_d;
      for (int k = 0; k < NKEYS; k++) key_st_q[k] <= key_st_d[k];
      for (int j = 0; j < 3*JOY_N; j++) joy_rows_q[j] <= joy_rows_d[j];
      if (latch_start) begin
        hold_cnt_q <= '0;
        hold_run_q <= 1'b1;
      end else if (hold_expire) begin
        hold_run_q <= 1'b0;
      end else if (hold_run_q) begin
        hold_cnt_q <= hold_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    all_or  = '0;
    sel_row = '0;
    for (int r = 0; r < NROWS; r++) begin
      all_or = all_or | row_data[r];
      if (int'(bus.addr) == r + 1) sel_row = row_data[r];
    end
  end

  assign bus.kb_rows = (bus.addr == ALL_ADDR) ? all_or : sel_row;

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// tb/tb_kbd_matrix_scan.sv - directed self-checking bench for kbd_matrix_scan
module tb_kbd_matrix_scan;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [63:0] joy;
  logic [10:0] fn;
  logic [2:0]  modif;
  int          n_run  = 0;
  int          n_fail = 0;

  kbd_matrix_scan_if bus_if ();

  kbd_matrix_scan dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_key (ps2_key),
    .joy     (joy),
    .fn      (fn),
    .modif   (modif),
    .bus     (bus_if)
  );

  always #10 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic look(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus_if.addr = a;
    #1;
    check_eq(tag, {24'd0, bus_if.kb_rows}, {24'd0, exp});
  endtask

  task automatic ps2_ev(input logic [7:0] code, input logic ext, input logic press);
    ps2_key = {~ps2_key[10], press, ext, code};
  endtask

  task automatic rd_pulse(input logic [7:0] a);
    bus_if.addr = a;
    bus_if.rd   = 1'b1;
    tick(1);
    bus_if.rd   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ps2_key = '0; joy = '0; bus_if.addr = 8'd0; bus_if.rd = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    look(8'h30, 8'h00, "rst_all_rows");
    check_eq("rst_fn", {21'd0, fn}, 32'd0);
    check_eq("rst_modif", {29'd0, modif}, 32'd0);

    // A: two-cycle latency, latch on unread release, clear one cycle after read
    ps2_ev(8'h1c, 1'b0, 1'b1); tick(1);
    look(8'd3, 8'h00, "a_not_yet");
    tick(1);
    look(8'd3, 8'h02, "a_press");
    ps2_ev(8'h1c, 1'b0, 1'b0); tick(2);
    look(8'd3, 8'h02, "a_latched");
    rd_pulse(8'd3);
    look(8'd3, 8'h02, "a_seen_cycle");
    tick(1);
    look(8'd3, 8'h00, "a_cleared");

    // B: tap stays visible until read, then TAP_HOLD timeout
    ps2_ev(8'h32, 1'b0, 1'b1); tick(2);
    ps2_ev(8'h32, 1'b0, 1'b0); tick(2);
    tick(10);
    look(8'd3, 8'h04, "b_unread");
    rd_pulse(8'd3); tick(1);
    look(8'd3, 8'h00, "b_read_clear");
    ps2_ev(8'h32, 1'b0, 1'b1); tick(2);
    ps2_ev(8'h32, 1'b0, 1'b0); tick(2);
    tick(4096 - 1);
    look(8'd3, 8'h04, "b_hold_last");
    tick(1);
    look(8'd3, 8'h00, "b_hold_expire");

    ps2_ev(8'h1c, 1'b1, 1'b1); tick(2);
    look(8'h30, 8'h00, "invalid_code");

    ps2_ev(8'h78, 1'b0, 1'b1); tick(2);
    check_eq("f11_fn", {21'd0, fn}, 32'h400);
    ps2_ev(8'h78, 1'b0, 1'b0); tick(2);
    check_eq("f11_rel", {21'd0, fn}, 32'h0);

    ps2_ev(8'h11, 1'b0, 1'b1); tick(2);
    check_eq("alt_modif", {29'd0, modif}, 32'h2);
    look(8'd7, 8'h04, "alt_row");
    ps2_ev(8'h11, 1'b0, 1'b0); tick(2);
    look(8'd7, 8'h04, "alt_latched");
    rd_pulse(8'h30); tick(1);
    look(8'd7, 8'h00, "alt_all_rd_clear");
    check_eq("alt_modif_rel", {29'd0, modif}, 32'h0);

    // Joysticks: ch1 up+left+fire1, then ch1 also right (UL wins), ch0 down+right+fire2
    joy[32+3] = 1'b1; joy[32+1] = 1'b1; joy[32+4] = 1'b1;
    tick(1);
    look(8'd13, 8'hAA, "joy_ul_r0");
    look(8'd14, 8'h00, "joy_ul_r1");
    look(8'd15, 8'h00, "joy_ul_r2");
    look(8'h30, 8'hAA, "joy_all");
    joy[32+0] = 1'b1; joy[2] = 1'b1; joy[0] = 1'b1; joy[5] = 1'b1;
    tick(1);
    look(8'd13, 8'hAA, "joy_ul_prio");
    look(8'd14, 8'h00, "joy_ur_masked");
    look(8'd10, 8'h00, "joy_dr_r0");
    look(8'd12, 8'hAA, "joy_dr_r2");
    joy = '0; joy[3] = 1'b1;
    tick(1);
    look(8'd10, 8'h11, "joy_up_only");
    joy = '0;
    tick(1);
    look(8'h30, 8'h00, "joy_released");

    // C: repeat press lands with a read of its row; press must win
    ps2_ev(8'h21, 1'b0, 1'b1); tick(2);
    ps2_ev(8'h21, 1'b0, 1'b1); tick(1);
    rd_pulse(8'd3);
    look(8'd3, 8'h08, "c_down");
    ps2_ev(8'h21, 1'b0, 1'b0); tick(2);
    tick(3);
    look(8'd3, 8'h08, "c_press_won");
    rd_pulse(8'd3); tick(1);
    look(8'd3, 8'h00, "c_cleared");

    ps2_ev(8'h1c, 1'b0, 1'b1); tick(2);
    look(8'd0, 8'h00, "addr_zero");
    look(8'd16, 8'h00, "addr_past_end");
    look(8'd3, 8'h02, "addr_held");

    // Reset with ctrl+F1 held and a toggle arriving during reset
    ps2_ev(8'h14, 1'b0, 1'b1); tick(2);
    ps2_ev(8'h05, 1'b0, 1'b1); tick(2);
    check_eq("ctrl_modif", {29'd0, modif}, 32'h4);
    check_eq("f1_fn", {21'd0, fn}, 32'h1);
    look(8'd7, 8'h22, "ctrl_f1_row");
    reset = 1'b1;
    ps2_ev(8'h32, 1'b0, 1'b1);
    tick(1);
    reset = 1'b0;
    look(8'h30, 8'h00, "rst2_all");
    check_eq("rst2_fn", {21'd0, fn}, 32'd0);
    check_eq("rst2_modif", {29'd0, modif}, 32'd0);
    tick(3);
    look(8'h30, 8'h00, "rst2_no_event");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
